// File: rtl/calc_pkg.sv
// Constants shared between the binary-to-BCD converter and the display driver.
package calc_pkg;

  localparam logic [3:0] BCD_MINUS = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ZERO  = 4'h0;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StShift  = 3'd2;
  localparam logic [2:0] StFormat = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam int unsigned DISP_MAX_POS = 9999;
  localparam int unsigned DISP_MAX_NEG = 999;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/signed_bin_to_bcd.sv
// Sequential signed binary to 4-digit display code converter (double dabble).
// Negative values carry a minus code in the top digit; optional leading-zero blanking.
module signed_bin_to_bcd
  import calc_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin_in,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [15:0]  bcd_out
);

  localparam int unsigned CW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [15:0] BcdRst = BLANK_LZ ? 16'hFFF0 : 16'h0000;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mag_q, mag_d;
  logic          neg_q, neg_d;
  logic          rng_q, rng_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          ovf_q, ovf_d;

  logic [15:0]   adj;
  logic [W-1:0]  mag_abs;
  logic          out_of_range;
  logic [15:0]   fmt;
  logic          lead;

  for (genvar g = 0; g < 4; g++) begin : gen_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // mag_q holds the raw captured operand while in LOAD; -2^(W-1) maps to 2^(W-1).
  assign mag_abs      = mag_q[W-1] ? -mag_q : mag_q;
  assign out_of_range = (!mag_q[W-1] && (32'(mag_abs) > DISP_MAX_POS)) ||
                        ( mag_q[W-1] && (32'(mag_abs) > DISP_MAX_NEG));

  always_comb begin
    fmt  = scratch_q;
    lead = 1'b1;
    if (rng_q) begin
      fmt = 16'hFFFF;
    end else begin
      if (neg_q) fmt[15:12] = BCD_MINUS;
      if (BLANK_LZ) begin
        // The minus sign is never blanked and stops nothing; scanning starts at d2.
        if (!neg_q) begin
          if (fmt[15:12] == BCD_ZERO) fmt[15:12] = BCD_BLANK;
          else                        lead = 1'b0;
        end
        if (lead && fmt[11:8] == BCD_ZERO) fmt[11:8] = BCD_BLANK;
        else                               lead = 1'b0;
        if (lead && fmt[7:4] == BCD_ZERO)  fmt[7:4] = BCD_BLANK;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    rng_d     = rng_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_d   = bin_in;
          state_d = StLoad;
        end
      end
      StLoad: begin
        neg_d     = mag_q[W-1];
        mag_d     = mag_abs;
        rng_d     = out_of_range;
        scratch_d = '0;
        cnt_d     = CW'(W - 1);
        state_d   = StShift;
      end
      StShift: begin
        scratch_d = {adj[14:0], mag_q[W-1]};
        mag_d     = {mag_q[W-2:0], 1'b0};
        if (cnt_q == '0) state_d = StFormat;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StFormat: begin
        bcd_d   = fmt;
        ovf_d   = rng_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      rng_q     <= 1'b0;
      scratch_q <= '0;
      bcd_q     <= BcdRst;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      rng_q     <= rng_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign ovf     = ovf_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_signed_bin_to_bcd.sv
// Scoreboard bench for signed_bin_to_bcd: one instance per BLANK_LZ setting, shared stimulus.
module tb_signed_bin_to_bcd;

  localparam int unsigned W = 16;

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e0;
    logic        eovf;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] bin_in = '0;
  logic         busy1, done1, ovf1, busy0, done0, ovf0;
  logic [15:0]  bcd1, bcd0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signed_bin_to_bcd #(.W(W), .BLANK_LZ(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd_out(bcd1)
  );

  signed_bin_to_bcd #(.W(W), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd_out(bcd0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done1 || done0) begin
      chk("done_align", 32'(done0), 32'(done1));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bcd=%h expected no done", bcd1);
      end else begin
        mon_e = sb.pop_front();
        chk("bcd_lz1", 32'(bcd1), 32'(mon_e.e1));
        chk("bcd_lz0", 32'(bcd0), 32'(mon_e.e0));
        chk("ovf", 32'(ovf1), 32'(mon_e.eovf));
        if (mon_e.cyc >= 0) chk("latency", cyc - mon_e.cyc, W + 3);
        else                chk("period", cyc - last_done, W + 4);
      end
      last_done = cyc;
    end
  end

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done1; i++) @(negedge clk);
    chk("done_timeout", 32'(done1), 32'd1);
  endtask

  task automatic convert(input logic [W-1:0] v, input logic [15:0] e1,
                         input logic [15:0] e0, input logic eo);
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    sb.push_back('{e1, e0, eo, cyc});
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    for (int i = 0; i < W + 10; i++) begin
      if (!busy1 || !busy0) bad = 1'b1;
      if (done1) break;
      @(negedge clk);
    end
    chk("busy_during", 32'(bad), 32'd0);
    chk("done_seen", 32'(done1), 32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_bcd_lz1", 32'(bcd1), 32'hFFF0);
    chk("rst_bcd_lz0", 32'(bcd0), 32'h0000);
    rst = 1'b0;

    convert(16'd1234,    16'h1234, 16'h1234, 1'b0);
    convert(-16'sd42,    16'hEF42, 16'hE042, 1'b0);
    convert(16'd0,       16'hFFF0, 16'h0000, 1'b0);
    convert(16'd100,     16'hF100, 16'h0100, 1'b0);
    convert(16'd9999,    16'h9999, 16'h9999, 1'b0);
    convert(16'd10000,   16'hFFFF, 16'hFFFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_hold", 32'(ovf1), 32'd1);
    chk("bcd_hold", 32'(bcd1), 32'hFFFF);
    convert(-16'sd999,   16'hE999, 16'hE999, 1'b0);
    convert(-16'sd100,   16'hE100, 16'hE100, 1'b0);
    convert(-16'sd1000,  16'hFFFF, 16'hFFFF, 1'b1);
    convert(16'h8000,    16'hFFFF, 16'hFFFF, 1'b1);
    convert(16'd32767,   16'hFFFF, 16'hFFFF, 1'b1);

    // Starts during busy and a changing operand must not disturb the first capture.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd555;
    sb.push_back('{16'hF555, 16'h0555, 1'b0, cyc});
    @(negedge clk);
    start  = 1'b0;
    bin_in = -16'sd3;
    repeat (3) @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd1111;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(W + 10);
    repeat (W + 8) @(negedge clk);
    chk("ignored_starts_sb", 32'(sb.size()), 32'd0);

    // Reset during SHIFT aborts the conversion without a done pulse.
    convert(16'd32767, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd1234;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_ovf", 32'(ovf1), 32'd0);
    chk("abort_bcd_lz1", 32'(bcd1), 32'hFFF0);
    chk("abort_bcd_lz0", 32'(bcd0), 32'h0000);
    repeat (W + 8) @(negedge clk);
    convert(16'd5, 16'hFFF5, 16'h0005, 1'b0);

    // Start held high: back-to-back conversions alternating 7 and -7.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd7;
    sb.push_back('{16'hFFF7, 16'h0007, 1'b0, cyc});
    for (int k = 0; k < 4; k++) begin
      wait_done(W + 10);
      if (k == 3) begin
        start = 1'b0;
      end else if (k % 2 == 0) begin
        bin_in = -16'sd7;
        sb.push_back('{16'hEFF7, 16'hE007, 1'b0, -1});
      end else begin
        bin_in = 16'd7;
        sb.push_back('{16'hFFF7, 16'h0007, 1'b0, -1});
      end
      @(negedge clk);
    end
    repeat (W + 8) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
